intr_ctrl: RTL and testbench
============================

// Module: intr_ctrl
// PURPOSE
//  Interrupt controller feeding INTR to the multicycle CU FSM and consuming its INT_TAKEN pulse.
//  Synchronises N_SRC external lines and detects edge or level per source; holds pending/enable state.
//  Selects the highest-priority source and presents a single INTR request to the FSM.
//  Memory-mapped on the MMIO data port, so software can enable, clear, claim and end-of-interrupt (EOI).
// PARAMETERS
//  N_SRC        8   number of interrupt sources (1..31); source 0 = highest priority
//  SYNC_STAGES  2   synchroniser flops per source input (>=2)
// PORTS
//  CLK        in   1      system clock, all logic on posedge
//  RST        in   1      reset, synchronous, active-low
//  IRQ_IN     in   N_SRC  asynchronous external interrupt lines
//  INT_TAKEN  in   1      1-cycle pulse from CU FSM: interrupt state entered
//  BUS_ADDR   in   4      register byte offset; only [3:2] decoded
//  BUS_WDATA  in   32     write data
//  BUS_WE     in   1      register write strobe, 1 cycle
//  BUS_RE     in   1      register read strobe, 1 cycle
//  BUS_RDATA  out  32     read data, registered
//  INTR       out  1      interrupt request to CU FSM (gated there by CSR_MIE)
//  IRQ_ID     out  5      ID of the source being serviced; valid while BUSY=1
//  BUSY       out  1      an interrupt is claimed and awaiting EOI
// BEHAVIOUR
//  Reset (RST==0 at posedge):
//   - ENABLE, PENDING, EDGE_SEL, sync/edge flops, BUSY, IRQ_ID cleared; BUS_RDATA=0, INTR=0.
//  Register map (offset):
//   - 0x0 ENABLE   R/W [N_SRC-1:0]
//   - 0x4 PENDING  R; write-1-to-clear, edge sources only
//   - 0x8 EDGE_SEL R/W; 1=rising-edge, 0=level
//   - 0xC CLAIM    R={BUSY,26'b0,IRQ_ID}; any write = EOI
//   - Unused bits read 0.
//  Input path:
//   - IRQ_IN[i] passes SYNC_STAGES flops, then a 1-flop edge detector.
//  Pending:
//   - Edge source: bit set on a synced 0->1; cleared by W1C or by being claimed.
//   - Same-cycle set and clear: set wins.
//   - Level source: PENDING[i] = synced level; W1C and claim have no effect.
//  Request:
//   - INTR = |(PENDING & ENABLE) & ~BUSY, combinational from registers.
//   - Latency IRQ_IN edge -> INTR = SYNC_STAGES+1 cycles (edge) or SYNC_STAGES (level).
//  Selection:
//   - Fixed priority; lowest index among PENDING&ENABLE wins.
//   - Recomputed every cycle; no stickiness before claim.
//  Claim:
//   - INT_TAKEN with a candidate present: BUSY<=1, IRQ_ID<=winner, clear winner's PENDING if edge.
//   - INT_TAKEN with no candidate: ignored, no state change.
//   - INT_TAKEN while BUSY=1: ignored.
//  EOI:
//   - Write to 0xC: BUSY<=0 next cycle; IRQ_ID holds its value.
//   - INT_TAKEN and EOI in the same cycle, BUSY=1: EOI applies first, then claim; BUSY stays 1 with the new IRQ_ID.
//  Bus:
//   - BUS_RDATA updates on the posedge after BUS_RE and holds until the next read.
//   - WE and RE in the same cycle: write performed, read returns pre-write value.
//   - Bus accesses never stall.
//  Reset mid-operation: all state dropped; a line held high afterwards re-pends.
//   - Level source: re-pends after SYNC_STAGES cycles.
//   - Edge source: re-pends only on a new 0->1.
//  Config change: disabling a source while BUSY does not alter BUSY/IRQ_ID.
// STRUCTURE
//  Package intr_pkg:
//   - offsets INTR_OFF_ENABLE/PENDING/EDGE_SEL/CLAIM
//   - localparam ID_W=5
//   - function prio_enc(N_SRC-bit vector) -> {valid, id}
//  Sub-module intr_sync_edge (per source, generate loop):
//   - synchroniser + edge detector
//   - outputs level and rise_pulse
//  Top: register file, pending logic, priority encode, claim/EOI FSM (IDLE/BUSY).
// TESTING
//  1. Hold RST=0 3 cycles with IRQ_IN=8'hFF -> INTR=0, BUS_RDATA=0; after release, level srcs with ENABLE=0 -> PENDING=FF, INTR=0.
//  2. EDGE_SEL=FF, ENABLE=0x24, pulse IRQ_IN[5] then [2] -> INTR after 3 cycles; INT_TAKEN -> IRQ_ID=2, BUSY=1, PENDING=0x20, INTR=0.
//  3. Continue: write CLAIM (EOI) -> BUSY=0, INTR=1 next cycle; INT_TAKEN -> IRQ_ID=5, PENDING=0.
//  4. Edge src 3 pending, W1C 0x08 in the same cycle as a new rise on src 3 -> PENDING[3] stays 1.
//  5. Level src 0 held high, ENABLE=1 -> claim/EOI loop re-asserts INTR each time; W1C on 0x4 bit0 has no effect.
//  6. BUSY=1 with src 1 pending: EOI + INT_TAKEN same cycle -> BUSY=1, IRQ_ID=1; INT_TAKEN with nothing pending -> unchanged.

Source files
------------

// File: rtl/intr_pkg.sv
// ---------------------------------------------------------------------------
// intr_pkg
//   Shared definitions for the interrupt controller: register offsets,
//   claim/EOI state encoding, and the fixed-priority encoder used to pick
//   the source presented to the CU FSM.
// ---------------------------------------------------------------------------
package intr_pkg;

    // Width of a source ID (enough for up to 31 sources)
    localparam int ID_W   = 5;
    // Width of the vector accepted by the priority encoder
    localparam int PRIO_W = 32;

    // Register byte offsets on the MMIO data port
    localparam logic [3:0] INTR_OFF_ENABLE   = 4'h0;
    localparam logic [3:0] INTR_OFF_PENDING  = 4'h4;
    localparam logic [3:0] INTR_OFF_EDGE_SEL = 4'h8;
    localparam logic [3:0] INTR_OFF_CLAIM    = 4'hC;

    // Only address bits [3:2] select a register; these are the word indices
    localparam logic [1:0] REG_IDX_ENABLE   = INTR_OFF_ENABLE[3:2];
    localparam logic [1:0] REG_IDX_PENDING  = INTR_OFF_PENDING[3:2];
    localparam logic [1:0] REG_IDX_EDGE_SEL = INTR_OFF_EDGE_SEL[3:2];
    localparam logic [1:0] REG_IDX_CLAIM    = INTR_OFF_CLAIM[3:2];

    // Claim/EOI state: IDLE = free to claim, BUSY = claimed, awaiting EOI
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } intr_state_e;

    // Result of the priority encoder
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } prio_t;

    // Fixed priority: lowest set index wins. Scanning from the top down and
    // overwriting means the last hit (the lowest index) is what remains.
    function automatic prio_t prio_enc(input logic [PRIO_W-1:0] vec);
        prio_t res;
        res.valid = 1'b0;
        res.id    = {ID_W{1'b0}};
        for (int i = PRIO_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res.valid = 1'b1;
                res.id    = i[ID_W-1:0];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/intr_sync_edge.sv
// ---------------------------------------------------------------------------
// intr_sync_edge
//   One interrupt input: SYNC_STAGES-deep synchroniser followed by a single
//   flop rising-edge detector.
// Ports
//   CLK        in  system clock
//   RST        in  synchronous active-low reset
//   irq_in     in  asynchronous external line
//   level      out synchronised level (last synchroniser flop)
//   rise_pulse out one-cycle pulse on a synchronised 0->1
// ---------------------------------------------------------------------------
module intr_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic irq_in,
    output logic level,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    // Next-state for the shift chain and the edge-detector history flop
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and edge-history registers
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level      = sync_q[SYNC_STAGES-1];
    assign rise_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/intr_ctrl.sv
// ---------------------------------------------------------------------------
// intr_ctrl
//   Interrupt controller in front of the multicycle CU FSM. Synchronises
//   N_SRC lines, tracks pending state per source (edge or level), selects the
//   lowest-index enabled pending source and raises INTR. The CU answers with
//   INT_TAKEN; software ends service with a write to CLAIM (EOI).
// Ports
//   CLK, RST   clock / synchronous active-low reset
//   IRQ_IN     asynchronous interrupt lines
//   INT_TAKEN  one-cycle pulse from the CU: interrupt state entered
//   BUS_ADDR   register byte offset ([3:2] decoded)
//   BUS_WDATA  write data
//   BUS_WE     write strobe
//   BUS_RE     read strobe
//   BUS_RDATA  registered read data, held until the next read
//   INTR       request to the CU
//   IRQ_ID     ID of the source in service (valid while BUSY)
//   BUSY       a source is claimed and awaiting EOI
// Registers: 0x0 ENABLE, 0x4 PENDING (W1C, edge only), 0x8 EDGE_SEL,
//            0xC CLAIM (read {BUSY,0,IRQ_ID}, any write = EOI)
// ---------------------------------------------------------------------------
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int N_SRC       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_SRC-1:0] IRQ_IN,
    input  logic             INT_TAKEN,
    input  logic [3:0]       BUS_ADDR,
    input  logic [31:0]      BUS_WDATA,
    input  logic             BUS_WE,
    input  logic             BUS_RE,
    output logic [31:0]      BUS_RDATA,
    output logic             INTR,
    output logic [ID_W-1:0]  IRQ_ID,
    output logic             BUSY
);

    // Register state
    logic [N_SRC-1:0] enable_q,    enable_d;
    logic [N_SRC-1:0] edge_sel_q,  edge_sel_d;
    logic [N_SRC-1:0] pend_edge_q, pend_edge_d;
    logic [ID_W-1:0]  irq_id_q,    irq_id_d;
    logic [31:0]      rdata_q,     rdata_d;
    intr_state_e      state_q,     state_d;

    // Combinational helpers
    logic [N_SRC-1:0] level_s;
    logic [N_SRC-1:0] rise_s;
    logic [N_SRC-1:0] pending_s;
    logic [N_SRC-1:0] cand_s;
    logic [N_SRC-1:0] w1c_mask_s;
    logic [N_SRC-1:0] claim_mask_s;
    logic [PRIO_W-1:0] cand_ext_s;
    prio_t            win_s;
    logic [1:0]       reg_idx_s;
    logic             wr_enable_s;
    logic             wr_pending_s;
    logic             wr_edge_sel_s;
    logic             eoi_s;
    logic             claim_s;
    logic             unused_bits_s;

    // Address bits below the word index and data bits above the source
    // count carry no meaning.
    assign unused_bits_s = &{1'b0, BUS_ADDR[1:0], BUS_WDATA[31:N_SRC]};

    // Per-source input conditioning
    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        intr_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync_edge (
            .CLK        (CLK),
            .RST        (RST),
            .irq_in     (IRQ_IN[g]),
            .level      (level_s[g]),
            .rise_pulse (rise_s[g])
        );
    end

    // Bus decode, visible pending vector and winner selection
    always_comb begin
        reg_idx_s     = BUS_ADDR[3:2];
        wr_enable_s   = BUS_WE & (reg_idx_s == REG_IDX_ENABLE);
        wr_pending_s  = BUS_WE & (reg_idx_s == REG_IDX_PENDING);
        wr_edge_sel_s = BUS_WE & (reg_idx_s == REG_IDX_EDGE_SEL);
        eoi_s         = BUS_WE & (reg_idx_s == REG_IDX_CLAIM);

        // Level sources mirror the synchronised line; edge sources use the latch
        pending_s  = (edge_sel_q & pend_edge_q) | (~edge_sel_q & level_s);
        cand_s     = pending_s & enable_q;
        cand_ext_s = {PRIO_W{1'b0}};
        cand_ext_s[N_SRC-1:0] = cand_s;
        win_s      = prio_enc(cand_ext_s);

        // A claim is accepted when idle, or when an EOI frees the slot in
        // the same cycle (EOI is applied first, then the new claim).
        claim_s = INT_TAKEN & win_s.valid & ((state_q == ST_IDLE) | eoi_s);

        w1c_mask_s = wr_pending_s ? BUS_WDATA[N_SRC-1:0] : {N_SRC{1'b0}};
        for (int i = 0; i < N_SRC; i++) begin
            claim_mask_s[i] = claim_s & (win_s.id == i[ID_W-1:0]);
        end
    end

    // Register-file and edge-pending next state; a new rise beats any clear
    always_comb begin
        enable_d    = wr_enable_s   ? BUS_WDATA[N_SRC-1:0] : enable_q;
        edge_sel_d  = wr_edge_sel_s ? BUS_WDATA[N_SRC-1:0] : edge_sel_q;
        // Masking with edge_sel keeps the latch empty for level sources, so
        // switching a source to edge mode never exposes a stale bit.
        pend_edge_d = edge_sel_q &
                      (rise_s | (pend_edge_q & ~w1c_mask_s & ~claim_mask_s));
    end

    // Claim/EOI state machine next state
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        case (state_q)
            ST_IDLE: begin
                if (claim_s) begin
                    state_d  = ST_BUSY;
                    irq_id_d = win_s.id;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (claim_s) begin
                    state_d  = ST_BUSY;
                    irq_id_d = win_s.id;
                end else if (eoi_s) begin
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_BUSY;
                end
            end
            default: begin
                state_d  = ST_IDLE;
            end
        endcase
    end

    // Read data mux; samples pre-write register values
    always_comb begin
        rdata_d = rdata_q;
        if (BUS_RE) begin
            rdata_d = 32'h0000_0000;
            case (reg_idx_s)
                REG_IDX_ENABLE:   rdata_d[N_SRC-1:0] = enable_q;
                REG_IDX_PENDING:  rdata_d[N_SRC-1:0] = pending_s;
                REG_IDX_EDGE_SEL: rdata_d[N_SRC-1:0] = edge_sel_q;
                REG_IDX_CLAIM:    rdata_d = {(state_q == ST_BUSY), 26'd0, irq_id_q};
                default:          rdata_d = 32'h0000_0000;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State registers
    always_ff @(posedge CLK) begin
        if (!RST) begin
            enable_q    <= {N_SRC{1'b0}};
            edge_sel_q  <= {N_SRC{1'b0}};
            pend_edge_q <= {N_SRC{1'b0}};
            irq_id_q    <= {ID_W{1'b0}};
            rdata_q     <= 32'h0000_0000;
            state_q     <= ST_IDLE;
        end else begin
            enable_q    <= enable_d;
            edge_sel_q  <= edge_sel_d;
            pend_edge_q <= pend_edge_d;
            irq_id_q    <= irq_id_d;
            rdata_q     <= rdata_d;
            state_q     <= state_d;
        end
    end

    assign BUS_RDATA = rdata_q;
    assign BUSY      = (state_q == ST_BUSY);
    assign IRQ_ID    = irq_id_q;
    // Request is a pure function of registers so the CU sees a clean level
    assign INTR      = (|cand_s) & (state_q == ST_IDLE);

endmodule

// File: tb/tb_intr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_intr_ctrl
//   Self-checking bench for intr_ctrl (N_SRC=8, SYNC_STAGES=2). Inputs are
//   driven on the falling edge and outputs sampled on the falling edge.
//   Expected read data is queued before each bus read and popped afterwards.
// ---------------------------------------------------------------------------
module tb_intr_ctrl;

    localparam logic [3:0] A_EN   = 4'h0;
    localparam logic [3:0] A_PEND = 4'h4;
    localparam logic [3:0] A_EDGE = 4'h8;
    localparam logic [3:0] A_CLM  = 4'hC;

    logic        CLK;
    logic        RST;
    logic [7:0]  IRQ_IN;
    logic        INT_TAKEN;
    logic [3:0]  BUS_ADDR;
    logic [31:0] BUS_WDATA;
    logic        BUS_WE;
    logic        BUS_RE;
    logic [31:0] BUS_RDATA;
    logic        INTR;
    logic [4:0]  IRQ_ID;
    logic        BUSY;

    int          n_cmp;
    int          n_bad;
    logic [31:0] exp_q[$];
    logic [31:0] rd;
    logic [31:0] exp_v;

    intr_ctrl #(.N_SRC(8), .SYNC_STAGES(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IRQ_IN    (IRQ_IN),
        .INT_TAKEN (INT_TAKEN),
        .BUS_ADDR  (BUS_ADDR),
        .BUS_WDATA (BUS_WDATA),
        .BUS_WE    (BUS_WE),
        .BUS_RE    (BUS_RE),
        .BUS_RDATA (BUS_RDATA),
        .INTR      (INTR),
        .IRQ_ID    (IRQ_ID),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // All tasks start and end on a falling edge
    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        BUS_ADDR = a; BUS_WDATA = d; BUS_WE = 1'b1;
        @(negedge CLK);
        BUS_WE = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a, output logic [31:0] d);
        BUS_ADDR = a; BUS_RE = 1'b1;
        @(negedge CLK);
        BUS_RE = 1'b0;
        d = BUS_RDATA;
    endtask

    task automatic pulse_taken();
        INT_TAKEN = 1'b1;
        @(negedge CLK);
        INT_TAKEN = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0; IRQ_IN = 8'hFF;
        tick(3);
        n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL rst_intr: got %b want 0", INTR); end
        n_cmp++; if (BUS_RDATA !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", BUS_RDATA); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", BUSY); end
        RST = 1'b1;
        tick(2);
        exp_q.push_back(32'h0000_00FF); do_read(A_PEND, rd); exp_v = exp_q.pop_front();
        n_cmp++; if (rd !== exp_v) begin n_bad++; $display("FAIL rst_level_pend: got %h want %h", rd, exp_v); end
        n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL rst_intr_disabled: got %b want 0", INTR); end
    endtask

    task automatic test_edge_claim();
        IRQ_IN = 8'h00;
        tick(3);
        do_write(A_EDGE, 32'h0000_00FF);
        do_write(A_EN,   32'h0000_0024);
        exp_q.push_back(32'h0000_0000); do_read(A_PEND, rd); exp_v = exp_q.pop_front();
        n_cmp++; if (rd !== exp_v) begin n_bad++; $display("FAIL edge_idle_pend: got %h want %h", rd, exp_v); end
        IRQ_IN = 8'h20; tick(1);
        IRQ_IN = 8'h04; tick(1);
        IRQ_IN = 8'h00;
        n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL edge_intr_early: got %b want 0", INTR); end
        tick(1);
        n_cmp++; if (INTR !== 1'b1) begin n_bad++; $display("FAIL edge_intr_latency: got %b want 1", INTR); end
        tick(1);
        pulse_taken();
        n_cmp++; if (IRQ_ID !== 5'd2) begin n_bad++; $display("FAIL claim_id: got %0d want 2", IRQ_ID); end
        n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL claim_busy: got %b want 1", BUSY); end
        n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL claim_intr: got %b want 0", INTR); end
        exp_q.push_back(32'h0000_0020); do_read(A_PEND, rd); exp_v = exp_q.pop_front();
        n_cmp++; if (rd !== exp_v) begin n_bad++; $display("FAIL claim_pend: got %h want %h", rd, exp_v); end
    endtask

    task automatic test_eoi();
        do_write(A_CLM, 32'h0000_0000);
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL eoi_busy: got %b want 0", BUSY); end
        n_cmp++; if (INTR !== 1'b1) begin n_bad++; $display("FAIL eoi_intr: got %b want 1", INTR); end
        pulse_taken();
        n_cmp++; if (IRQ_ID !== 5'd5) begin n_bad++; $display("FAIL eoi_claim_id: got %0d want 5", IRQ_ID); end
        exp_q.push_back(32'h0000_0000); do_read(A_PEND, rd); exp_v = exp_q.pop_front();
        n_cmp++; if (rd !== exp_v) begin n_bad++; $display("FAIL eoi_pend: got %h want %h", rd, exp_v); end
        do_write(A_CLM, 32'h0000_0000);
        n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL eoi_idle_intr: got %b want 0", INTR); end
    endtask

    task automatic test_set_wins();
        IRQ_IN = 8'h08; tick(1);
        IRQ_IN = 8'h00; tick(2);
        exp_q.push_back(32'h0000_0008); do_read(A_PEND, rd); exp_v = exp_q.pop_front();
        n_cmp++; if (rd !== exp_v) begin n_bad++; $display("FAIL sw_pend_set: got %h want %h", rd, exp_v); end
        tick(2);
        IRQ_IN = 8'h08; tick(2);
        IRQ_IN = 8'h00;
        do_write(A_PEND, 32'h0000_0008);
        exp_q.push_back(32'h0000_0008); do_read(A_PEND, rd); exp_v = exp_q.pop_front();
        n_cmp++; if (rd !== exp_v) begin n_bad++; $display("FAIL sw_set_wins: got %h want %h", rd, exp_v); end
        do_write(A_PEND, 32'h0000_0008);
        exp_q.push_back(32'h0000_0000); do_read(A_PEND, rd); exp_v = exp_q.pop_front();
        n_cmp++; if (rd !== exp_v) begin n_bad++; $display("FAIL sw_w1c: got %h want %h", rd, exp_v); end
    endtask

    task automatic test_level_loop();
        do_write(A_EDGE, 32'h0000_00FE);
        do_write(A_EN,   32'h0000_0001);
        IRQ_IN = 8'h01;
        tick(2);
        n_cmp++; if (INTR !== 1'b1) begin n_bad++; $display("FAIL lvl_intr: got %b want 1", INTR); end
        for (int k = 0; k < 2; k++) begin
            pulse_taken();
            n_cmp++; if ({BUSY, IRQ_ID, INTR} !== {1'b1, 5'd0, 1'b0}) begin
                n_bad++; $display("FAIL lvl_claim%0d: got busy=%b id=%0d intr=%b want 1/0/0", k, BUSY, IRQ_ID, INTR);
            end
            do_write(A_CLM, 32'h0000_0000);
            n_cmp++; if (INTR !== 1'b1) begin n_bad++; $display("FAIL lvl_reassert%0d: got %b want 1", k, INTR); end
        end
        do_write(A_PEND, 32'h0000_0001);
        exp_q.push_back(32'h0000_0001); do_read(A_PEND, rd); exp_v = exp_q.pop_front();
        n_cmp++; if (rd !== exp_v) begin n_bad++; $display("FAIL lvl_w1c_noeffect: got %h want %h", rd, exp_v); end
        IRQ_IN = 8'h00;
        tick(3);
        n_cmp++; if (INTR !== 1'b0) begin n_bad++; $display("FAIL lvl_drop: got %b want 0", INTR); end
    endtask

    task automatic test_back_to_back();
        do_write(A_EDGE, 32'h0000_00FF);
        do_write(A_EN,   32'h0000_0003);
        IRQ_IN = 8'h03; tick(1);
        IRQ_IN = 8'h00; tick(2);
        pulse_taken();
        n_cmp++; if ({BUSY, IRQ_ID} !== {1'b1, 5'd0}) begin n_bad++; $display("FAIL b2b_first: got busy=%b id=%0d want 1/0", BUSY, IRQ_ID); end
        exp_q.push_back(32'h8000_0000); do_read(A_CLM, rd); exp_v = exp_q.pop_front();
        n_cmp++; if (rd !== exp_v) begin n_bad++; $display("FAIL b2b_claim_rd: got %h want %h", rd, exp_v); end
        INT_TAKEN = 1'b1;
        do_write(A_CLM, 32'h0000_0000);
        INT_TAKEN = 1'b0;
        n_cmp++; if ({BUSY, IRQ_ID} !== {1'b1, 5'd1}) begin n_bad++; $display("FAIL b2b_eoi_claim: got busy=%b id=%0d want 1/1", BUSY, IRQ_ID); end
        exp_q.push_back(32'h0000_0000); do_read(A_PEND, rd); exp_v = exp_q.pop_front();
        n_cmp++; if (rd !== exp_v) begin n_bad++; $display("FAIL b2b_pend: got %h want %h", rd, exp_v); end
        do_write(A_EN, 32'h0000_0000);
        pulse_taken();
        n_cmp++; if ({BUSY, IRQ_ID} !== {1'b1, 5'd1}) begin n_bad++; $display("FAIL b2b_busy_ignore: got busy=%b id=%0d want 1/1", BUSY, IRQ_ID); end
        do_write(A_CLM, 32'h0000_0000);
        pulse_taken();
        n_cmp++; if ({BUSY, IRQ_ID} !== {1'b0, 5'd1}) begin n_bad++; $display("FAIL b2b_nocand: got busy=%b id=%0d want 0/1", BUSY, IRQ_ID); end
        exp_q.push_back(32'h0000_0001); do_read(A_CLM, rd); exp_v = exp_q.pop_front();
        n_cmp++; if (rd !== exp_v) begin n_bad++; $display("FAIL b2b_idle_rd: got %h want %h", rd, exp_v); end
    endtask

    task automatic test_rw_same_cycle();
        exp_q.push_back(32'h0000_0000);
        BUS_ADDR = A_EN; BUS_WDATA = 32'h0000_005A; BUS_WE = 1'b1; BUS_RE = 1'b1;
        @(negedge CLK);
        BUS_WE = 1'b0; BUS_RE = 1'b0; rd = BUS_RDATA;
        exp_v = exp_q.pop_front();
        n_cmp++; if (rd !== exp_v) begin n_bad++; $display("FAIL rw_prewrite: got %h want %h", rd, exp_v); end
        exp_q.push_back(32'h0000_005A); do_read(A_EN, rd); exp_v = exp_q.pop_front();
        n_cmp++; if (rd !== exp_v) begin n_bad++; $display("FAIL rw_postwrite: got %h want %h", rd, exp_v); end
    endtask

    task automatic test_reset_mid();
        IRQ_IN = 8'h03;
        RST = 1'b0; tick(1);
        RST = 1'b1; tick(3);
        do_write(A_EDGE, 32'h0000_0002);
        tick(2);
        exp_q.push_back(32'h0000_0001); do_read(A_PEND, rd); exp_v = exp_q.pop_front();
        n_cmp++; if (rd !== exp_v) begin n_bad++; $display("FAIL rstmid_pend: got %h want %h", rd, exp_v); end
        exp_q.push_back(32'h0000_0000); do_read(A_EN, rd); exp_v = exp_q.pop_front();
        n_cmp++; if (rd !== exp_v) begin n_bad++; $display("FAIL rstmid_enable: got %h want %h", rd, exp_v); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        RST = 1'b0; IRQ_IN = 8'hFF; INT_TAKEN = 1'b0;
        BUS_ADDR = 4'h0; BUS_WDATA = 32'h0; BUS_WE = 1'b0; BUS_RE = 1'b0;
        @(negedge CLK);
        test_reset();
        test_edge_claim();
        test_eoi();
        test_set_wins();
        test_level_loop();
        test_back_to_back();
        test_rw_same_cycle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
